// File: rtl/pc_sequencer.sv
// Program-counter sequencer with trap/stall/redirect priority and a circular
// return-address stack that overwrites its oldest entry when full.
module pc_sequencer #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00003000,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h00004180,
   parameter int               STEP         = 4,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             stall,
   input  logic                             trap,
   input  logic                             redirectValid,
   input  logic [WIDTH-1:0]                 redirectTarget,
   input  logic                             isCall,
   input  logic                             isReturn,
   output logic [WIDTH-1:0]                 pcValue,
   output logic [WIDTH-1:0]                 pcNext,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   rasCount,
   output logic                             rasOverflow,
   output logic                             rasUnderflow
);

   localparam int CW = $clog2(RAS_DEPTH+1);
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [WIDTH-1:0] stack [0:RAS_DEPTH-1];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    topPtr;
   logic [PW-1:0]    wrPtrInc;
   logic [WIDTH-1:0] seqPc;
   logic             active;
   logic             doPush;
   logic             doPop;
   logic             doUnder;
   logic             full;

   // wrPtr is the next free slot; the top entry sits one below it, modulo depth.
   always_comb begin
      seqPc    = pcValue + WIDTH'(STEP);
      topPtr   = (wrPtr == '0) ? PW'(RAS_DEPTH-1) : wrPtr - PW'(1);
      wrPtrInc = (wrPtr == PW'(RAS_DEPTH-1)) ? '0 : wrPtr + PW'(1);
      full     = (rasCount == CW'(RAS_DEPTH));
      active   = !trap && !stall;
      doPop    = active && isReturn && (rasCount != '0);
      doUnder  = active && isReturn && (rasCount == '0);
      doPush   = active && redirectValid && isCall && !isReturn;
   end

   always_comb begin
      pcNext = seqPc;
      if (trap)
         pcNext = TRAP_VECTOR;
      else if (stall)
         pcNext = pcValue;
      else if (isReturn)
         pcNext = (rasCount != '0) ? stack[topPtr] : redirectTarget;
      else if (redirectValid)
         pcNext = redirectTarget;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pcValue      <= RESET_VECTOR;
         rasCount     <= '0;
         wrPtr        <= '0;
         rasOverflow  <= 1'b0;
         rasUnderflow <= 1'b0;
      end else begin
         pcValue      <= pcNext;
         rasOverflow  <= doPush && full;
         rasUnderflow <= doUnder;
         if (doPush) begin
            wrPtr <= wrPtrInc;
            if (!full)
               rasCount <= rasCount + CW'(1);
         end else if (doPop) begin
            wrPtr    <= topPtr;
            rasCount <= rasCount - CW'(1);
         end
      end
   end

   // Entry contents are only visible through rasCount, so they carry no reset.
   always_ff @(posedge clock) begin
      if (doPush)
         stack[wrPtr] <= seqPc;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven check of pc_sequencer plus hand sequences for reset timing.
module tb_pc_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall, trap, redirectValid, isCall, isReturn;
   logic [31:0] redirectTarget;
   logic [31:0] pcValue, pcNext;
   logic [2:0]  rasCount;
   logic        rasOverflow, rasUnderflow;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   pc_sequencer dut (
      .clock(clock), .reset(reset), .stall(stall), .trap(trap),
      .redirectValid(redirectValid), .redirectTarget(redirectTarget),
      .isCall(isCall), .isReturn(isReturn), .pcValue(pcValue), .pcNext(pcNext),
      .rasCount(rasCount), .rasOverflow(rasOverflow), .rasUnderflow(rasUnderflow)
   );

   typedef struct {
      logic        st, tr, rv, cl, rt;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic [2:0]  cnt;
      logic        ovf, unf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic st, logic tr, logic rv, logic cl, logic rt,
                               logic [31:0] tgt, logic [31:0] pc, logic [2:0] cnt,
                               logic ovf, logic unf);
      vec_t v;
      v.st = st; v.tr = tr; v.rv = rv; v.cl = cl; v.rt = rt;
      v.tgt = tgt; v.pc = pc; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
      end
   endtask

   task automatic idle_inputs();
      stall = 0; trap = 0; redirectValid = 0; isCall = 0; isReturn = 0;
      redirectTarget = 32'h0;
   endtask

   initial begin
      //        st tr rv cl rt  tgt            pc after edge  cnt ovf unf
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        32'h00003004, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        32'h00003008, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        32'h0000300C, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        32'h00003010, 0, 0, 0));
      vecs.push_back(mk(0,0,1,1,0, 32'h00005000, 32'h00005000, 1, 0, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h0,        32'h00003014, 0, 0, 0));
      // five nested calls, fifth evicts the oldest (3018)
      vecs.push_back(mk(0,0,1,1,0, 32'h00006000, 32'h00006000, 1, 0, 0));
      vecs.push_back(mk(0,0,1,1,0, 32'h00006100, 32'h00006100, 2, 0, 0));
      vecs.push_back(mk(0,0,1,1,0, 32'h00006200, 32'h00006200, 3, 0, 0));
      vecs.push_back(mk(0,0,1,1,0, 32'h00006300, 32'h00006300, 4, 0, 0));
      vecs.push_back(mk(0,0,1,1,0, 32'h00006400, 32'h00006400, 4, 1, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        32'h00006404, 4, 0, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h0,        32'h00006304, 3, 0, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h0,        32'h00006204, 2, 0, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h0,        32'h00006104, 1, 0, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h0,        32'h00006004, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,1, 32'h00007000, 32'h00007000, 0, 0, 1));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        32'h00007004, 0, 0, 0));
      // stall holds everything, trap overrides stall
      vecs.push_back(mk(0,0,1,1,0, 32'h00008000, 32'h00008000, 1, 0, 0));
      vecs.push_back(mk(1,0,1,0,0, 32'h00009000, 32'h00008000, 1, 0, 0));
      vecs.push_back(mk(1,0,1,1,0, 32'h00009000, 32'h00008000, 1, 0, 0));
      vecs.push_back(mk(1,0,0,0,1, 32'h00009000, 32'h00008000, 1, 0, 0));
      vecs.push_back(mk(1,1,1,0,0, 32'h00009000, 32'h00004180, 1, 0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        32'h00004184, 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,1, 32'h0,        32'h00004180, 1, 0, 0));
      // call+return is a return only; call without redirect is ignored
      vecs.push_back(mk(0,0,1,1,1, 32'h0000A000, 32'h00007008, 0, 0, 0));
      vecs.push_back(mk(0,0,0,1,0, 32'h0000B000, 32'h0000700C, 0, 0, 0));
      // sequential wrap
      vecs.push_back(mk(0,0,1,0,0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0));
      vecs.push_back(mk(0,0,0,0,0, 32'h0,        32'h00000000, 0, 0, 0));
      vecs.push_back(mk(0,0,1,1,0, 32'h00000100, 32'h00000100, 1, 0, 0));

      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_pc", 0, pcValue, 32'h00003000);
      check("reset_cnt", 0, 32'(rasCount), 32'h0);
      check("reset_flags", 0, {30'b0, rasOverflow, rasUnderflow}, 32'h0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         stall = vecs[i].st; trap = vecs[i].tr; redirectValid = vecs[i].rv;
         isCall = vecs[i].cl; isReturn = vecs[i].rt; redirectTarget = vecs[i].tgt;
         #1;
         check("pcNext", i, pcNext, vecs[i].pc);
         @(posedge clock);
         #1;
         check("pcValue", i, pcValue, vecs[i].pc);
         check("rasCount", i, 32'(rasCount), 32'(vecs[i].cnt));
         check("rasOverflow", i, 32'(rasOverflow), 32'(vecs[i].ovf));
         check("rasUnderflow", i, 32'(rasUnderflow), 32'(vecs[i].unf));
         @(negedge clock);
      end

      // Reset pulsed between edges while a call is pending: must act at once.
      redirectValid = 1; isCall = 1; redirectTarget = 32'h0000C000;
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_pc", 100, pcValue, 32'h00003000);
      check("async_reset_cnt", 100, 32'(rasCount), 32'h0);
      @(posedge clock);
      #1;
      check("held_reset_pc", 101, pcValue, 32'h00003000);
      @(negedge clock);
      idle_inputs();
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("post_reset_pc", 102, pcValue, 32'h00003004);
      check("post_reset_cnt", 102, 32'(rasCount), 32'h0);
      // stack must be empty after reset: a return falls back to the target
      @(negedge clock);
      isReturn = 1; redirectTarget = 32'h0000D000;
      @(posedge clock);
      #1;
      check("post_reset_ret_pc", 103, pcValue, 32'h0000D000);
      check("post_reset_unf", 103, 32'(rasUnderflow), 32'h1);
      @(negedge clock);
      idle_inputs();
      @(posedge clock);
      #1;
      check("unf_clears", 104, 32'(rasUnderflow), 32'h0);
      check("after_ret_pc", 104, pcValue, 32'h0000D004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h00003000, meaning the PC value loaded on reset.
REQ-003 The block SHALL have parameter TRAP_VECTOR, default 32'h00004180, meaning the PC value loaded on trap.
REQ-004 The block SHALL have parameter STEP, default 4, meaning the sequential increment in bytes.
REQ-005 The block SHALL have parameter RAS_DEPTH, default 4 (minimum 1), meaning the number of return-address stack entries.
REQ-006 The block SHALL have port clock  input  1  meaning the single clock; all state updates on the rising edge.
REQ-007 The block SHALL have port reset  input  1  meaning reset, asynchronous, active-low (0 = reset).
REQ-008 The block SHALL have port stall  input  1  meaning hold the PC and stack this cycle.
REQ-009 The block SHALL have port trap  input  1  meaning redirect to TRAP_VECTOR.
REQ-010 The block SHALL have port redirectValid  input  1  meaning take redirectTarget (branch/jump/call).
REQ-011 The block SHALL have port redirectTarget  input  WIDTH  meaning the redirect or fallback destination.
REQ-012 The block SHALL have port isCall  input  1  meaning the redirect is a call; qualified by redirectValid.
REQ-013 The block SHALL have port isReturn  input  1  meaning return; pop the stack top as the destination.
REQ-014 The block SHALL have port pcValue  output  WIDTH  meaning the registered current PC.
REQ-015 The block SHALL have port pcNext  output  WIDTH  meaning the combinational value pcValue takes at the next edge.
REQ-016 The block SHALL have port rasCount  output  $clog2(RAS_DEPTH+1)  meaning the number of valid stack entries.
REQ-017 The block SHALL have port rasOverflow  output  1  meaning a registered one-cycle pulse when a push evicted the oldest entry.
REQ-018 The block SHALL have port rasUnderflow  output  1  meaning a registered one-cycle pulse when a return found the stack empty.

Function
REQ-019 pcNext SHALL be selected by priority: trap -> TRAP_VECTOR; else stall -> pcValue; else isReturn -> stack top, or redirectTarget if rasCount==0; else redirectValid -> redirectTarget; else pcValue+STEP.
REQ-020 pcValue SHALL load pcNext every rising edge with reset deasserted; single-cycle latency from any input to pcValue.
REQ-021 pcValue+STEP SHALL wrap modulo 2^WIDTH (e.g. 32'hFFFFFFFC+4 -> 32'h00000000) with no flag.
REQ-022 Push: when redirectValid & isCall & !isReturn & !stall & !trap, the block SHALL push pcValue+STEP (wrapped) and increment rasCount.
REQ-023 A push when rasCount==RAS_DEPTH SHALL overwrite the oldest entry, leave rasCount at RAS_DEPTH, and pulse rasOverflow next cycle.
REQ-024 Pop: when isReturn & !stall & !trap & rasCount>0, the block SHALL use the top entry as destination and decrement rasCount.
REQ-025 isReturn with rasCount==0 (no stall/trap) SHALL jump to redirectTarget, leave the stack unchanged, and pulse rasUnderflow next cycle.
REQ-026 isReturn & isCall together SHALL be treated as a return only; no push.
REQ-027 trap SHALL override stall and all other inputs; the stack SHALL be unchanged on trap.
REQ-028 During stall (no trap), pcValue, stack contents and rasCount SHALL hold; rasOverflow/rasUnderflow SHALL be 0.
REQ-029 rasOverflow and rasUnderflow SHALL be 0 in any cycle not following a qualifying event.
REQ-030 isCall without redirectValid SHALL have no effect.

Reset
REQ-031 reset low SHALL immediately (asynchronously) force pcValue=RESET_VECTOR, rasCount=0, rasOverflow=0, rasUnderflow=0, regardless of clock.
REQ-032 Stack entry contents need not be reset; they SHALL be unobservable while rasCount==0.
REQ-033 Reset asserted mid-operation (including during stall or a pending call) SHALL discard all state; the first edge after release SHALL produce RESET_VECTOR+STEP absent other inputs.
REQ-034 Reset release SHALL be synchronous to clock from the design's perspective; no edge in the release cycle shall load pcNext.

Verification
REQ-035 Reset then 3 idle edges -> pcValue 32'h00003000, 32'h00003004, 32'h00003008, 32'h0000300C; rasCount=0.
REQ-036 At pcValue=32'h00003010, call to 32'h00005000, then isReturn next cycle -> pcValue 32'h00005000 then 32'h00003014; rasCount 1 then 0.
REQ-037 Five nested calls with RAS_DEPTH=4 -> rasOverflow pulses once after the fifth; four returns yield the last four return addresses in LIFO order; fifth return jumps to redirectTarget with rasUnderflow pulse.
REQ-038 stall held 3 cycles with redirectValid=1 -> pcValue and rasCount unchanged; trap asserted during stall -> pcValue=32'h00004180 next edge.
REQ-039 redirectTarget=32'hFFFFFFFC then idle edge -> pcValue 32'h00000000, no flag.
REQ-040 reset pulsed low between clock edges during a call -> pcValue=32'h00003000 and rasCount=0 immediately, before the next edge.
